// File: rtl/gcd_engine.sv
// Subtract/swap Euclid GCD engine; optional SUB-cycle counter enabled by defining GCD_ITER_COUNT_EN.
// start is taken only in IDLE, done pulses one cycle after the terminating CHECK, abort drops the run silently.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [CNT_W-1:0] iter_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SWAP,
        S_SUB
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;

`ifdef GCD_ITER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
`endif

    if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
        $error("gcd_engine: WIDTH must be >= 2 and CNT_W >= 1");
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifdef GCD_ITER_COUNT_EN
        cnt_d   = cnt_q;
        iter_d  = iter_q;
`endif
        // abort outranks everything, including a start presented in IDLE
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_d     = a;
                        y_d     = b;
`ifdef GCD_ITER_COUNT_EN
                        cnt_d   = '0;
`endif
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (x_q == '0) begin
                        res_d   = y_q;
                        done_d  = 1'b1;
`ifdef GCD_ITER_COUNT_EN
                        iter_d  = cnt_q;
`endif
                        state_d = S_IDLE;
                    end else if (y_q == '0) begin
                        res_d   = x_q;
                        done_d  = 1'b1;
`ifdef GCD_ITER_COUNT_EN
                        iter_d  = cnt_q;
`endif
                        state_d = S_IDLE;
                    end else if (x_q >= y_q) begin
                        state_d = S_SUB;
                    end else begin
                        state_d = S_SWAP;
                    end
                end
                S_SWAP: begin
                    x_d     = y_q;
                    y_d     = x_q;
                    state_d = S_SUB;
                end
                S_SUB: begin
                    // x_q >= y_q is guaranteed on entry, so this cannot wrap
                    x_d     = x_q - y_q;
`ifdef GCD_ITER_COUNT_EN
                    if (!(&cnt_q)) begin
                        cnt_d = cnt_q + CntOne;
                    end
`endif
                    state_d = S_CHECK;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            cnt_q   <= '0;
            iter_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            done_q  <= done_d;
`ifdef GCD_ITER_COUNT_EN
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = res_q;
`ifdef GCD_ITER_COUNT_EN
    assign iter_count = iter_q;
`endif

endmodule
